// File: rtl/fetch_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// fetch_ctrl_pkg
//   Shared definitions for the instruction-fetch sequencer: word width,
//   instruction length, default PC step and the sequencer state encoding.
// -----------------------------------------------------------------------------
package fetch_ctrl_pkg;

  localparam int WORD            = 32;
  localparam int INSTR_LEN       = 4;
  localparam int PC_STEP_DEFAULT = INSTR_LEN;

  typedef logic [WORD-1:0] word_t;

  // Two-bit state encoding of the fetch sequencer.
  typedef enum logic [1:0] {
    FC_BOOT = 2'd0,
    FC_RUN  = 2'd1,
    FC_HALT = 2'd2
  } fc_state_e;

endpackage : fetch_ctrl_pkg

// File: rtl/fetch_ctrl_if.sv
// -----------------------------------------------------------------------------
// fetch_ctrl_if
//   Bundle between the hazard/branch logic (master) and the fetch sequencer
//   (slave).
//   master drives : stall, pc_src, branch_target, halt_req, resume
//   slave drives  : pc, fetch_valid, flush, fault, fetch_count
// -----------------------------------------------------------------------------
interface fetch_ctrl_if
  import fetch_ctrl_pkg::*;
();

  logic        stall;
  logic        pc_src;
  word_t       branch_target;
  logic        halt_req;
  logic        resume;

  word_t       pc;
  logic        fetch_valid;
  logic        flush;
  logic        fault;
  logic [31:0] fetch_count;

  modport master (
    output stall, pc_src, branch_target, halt_req, resume,
    input  pc, fetch_valid, flush, fault, fetch_count
  );

  modport slave (
    input  stall, pc_src, branch_target, halt_req, resume,
    output pc, fetch_valid, flush, fault, fetch_count
  );

endinterface : fetch_ctrl_if

// File: rtl/fetch_ctrl_pc_reg.sv
// -----------------------------------------------------------------------------
// fetch_ctrl_pc_reg
//   WORD-wide register with asynchronous active-high reset to RESET_VAL and a
//   load enable. Holds the program counter of the fetch sequencer.
//   Ports: clk, reset, load (capture d this edge), d (next value), q (value).
// -----------------------------------------------------------------------------
module fetch_ctrl_pc_reg
  import fetch_ctrl_pkg::*;
#(
  parameter word_t RESET_VAL = '0
) (
  input  logic  clk,
  input  logic  reset,
  input  logic  load,
  input  word_t d,
  output word_t q
);

  // NOTE: clocked state is written with non-blocking assignments so every
  // register samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)     q <= RESET_VAL;
    else if (load) q <= d;
  end

endmodule : fetch_ctrl_pc_reg

// File: rtl/fetch_ctrl.sv
// -----------------------------------------------------------------------------
// fetch_ctrl
//   Instruction-fetch sequencer. Owns the PC and each cycle holds it, steps it
//   by PC_STEP, or redirects it to a branch target. Provides a boot delay of
//   BOOT_CYCLES, halt/resume, a flush pulse for IF/ID and a sticky fault for
//   misaligned branch targets.
//   Ports: clk, reset (async, active-high), bus (fetch_ctrl_if.slave):
//     in : stall, pc_src, branch_target, halt_req, resume
//     out: pc, fault, fetch_count (registered); fetch_valid, flush (comb)
// -----------------------------------------------------------------------------
module fetch_ctrl
  import fetch_ctrl_pkg::*;
#(
  parameter word_t       RESET_PC    = '0,
  parameter int unsigned BOOT_CYCLES = 4,
  parameter word_t       PC_STEP     = word_t'(PC_STEP_DEFAULT)
) (
  input  logic         clk,
  input  logic         reset,
  fetch_ctrl_if.slave  bus
);

  localparam logic [7:0] BOOT_LAST = 8'(BOOT_CYCLES - 1);

  fc_state_e   state_q, state_d;
  logic [7:0]  boot_cnt_q;
  logic        fault_q;
  logic [31:0] fetch_count_q;
  word_t       pc_q, pc_d;

  logic        misaligned;
  logic        fetch_valid, flush, pc_load, count_inc, fault_set;

  assign misaligned = |bus.branch_target[1:0];

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= FC_BOOT;
    else       state_q <= state_d;
  end

  // Next-state logic.
  // NOTE: every combinational output gets a default before the case so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      FC_BOOT: if (boot_cnt_q == BOOT_LAST) state_d = FC_RUN;
      FC_RUN:  if (bus.halt_req || (bus.pc_src && misaligned)) state_d = FC_HALT;
      FC_HALT: if (bus.resume && !fault_q) state_d = FC_RUN;
      default: state_d = FC_BOOT;
    endcase
  end

  // Output / datapath-control logic. Only RUN acts on the inputs; halt_req
  // outranks a branch, and a branch outranks stall.
  always_comb begin
    fetch_valid = 1'b0;
    flush       = 1'b0;
    fault_set   = 1'b0;
    pc_load     = 1'b0;
    pc_d        = pc_q + PC_STEP;
    if (state_q == FC_RUN) begin
      fetch_valid = !bus.stall && !bus.halt_req;
      if (!bus.halt_req) begin
        if (bus.pc_src) begin
          flush = 1'b1;
          if (misaligned) begin
            fault_set = 1'b1;
          end else begin
            pc_load = 1'b1;
            pc_d    = bus.branch_target;
          end
        end else if (!bus.stall) begin
          pc_load = 1'b1;
        end
      end
    end
    // A flushed fetch is wrong-path work and does not count.
    count_inc = fetch_valid && !flush;
  end

  // Boot counter, sticky fault and fetch counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      boot_cnt_q    <= '0;
      fault_q       <= 1'b0;
      fetch_count_q <= '0;
    end else begin
      if (state_q == FC_BOOT) boot_cnt_q <= boot_cnt_q + 8'd1;
      if (fault_set)          fault_q <= 1'b1;
      if (count_inc)          fetch_count_q <= fetch_count_q + 32'd1;
    end
  end

  fetch_ctrl_pc_reg #(
    .RESET_VAL (RESET_PC)
  ) u_pc_reg (
    .clk   (clk),
    .reset (reset),
    .load  (pc_load),
    .d     (pc_d),
    .q     (pc_q)
  );

  assign bus.pc          = pc_q;
  assign bus.fetch_valid = fetch_valid;
  assign bus.flush       = flush;
  assign bus.fault       = fault_q;
  assign bus.fetch_count = fetch_count_q;

endmodule : fetch_ctrl

// File: tb/tb_fetch_ctrl.sv
// -----------------------------------------------------------------------------
// tb_fetch_ctrl
//   Self-checking bench for fetch_ctrl. dut_a (RESET_PC=0) is compared against
//   a behavioural model of the fetch rules; dut_b (RESET_PC=0xFFFFFFF8) covers
//   PC wrap-around.
// -----------------------------------------------------------------------------
module tb_fetch_ctrl;
  import fetch_ctrl_pkg::*;

  localparam int    BOOT  = 4;
  localparam word_t RPC_A = 32'h0000_0000;
  localparam word_t RPC_B = 32'hFFFF_FFF8;

  logic clk = 1'b0;
  logic reset_a;
  logic reset_b;

  int errors = 0;
  int checks = 0;

  fetch_ctrl_if bus_a ();
  fetch_ctrl_if bus_b ();

  fetch_ctrl #(.RESET_PC(RPC_A), .BOOT_CYCLES(BOOT), .PC_STEP(32'd4)) dut_a (
    .clk (clk), .reset (reset_a), .bus (bus_a)
  );

  fetch_ctrl #(.RESET_PC(RPC_B), .BOOT_CYCLES(BOOT), .PC_STEP(32'd4)) dut_b (
    .clk (clk), .reset (reset_b), .bus (bus_b)
  );

  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // Reference model: edges seen since reset, a halted flag, the sticky fault,
  // the PC and the count of useful fetches.
  // ---------------------------------------------------------------------------
  int          m_edges;
  bit          m_halted;
  bit          m_fault;
  word_t       m_pc;
  logic [31:0] m_cnt;

  function automatic bit m_running();
    return (m_edges >= BOOT) && !m_halted;
  endfunction

  function automatic bit exp_valid();
    return m_running() && !bus_a.stall && !bus_a.halt_req;
  endfunction

  function automatic bit exp_flush();
    return m_running() && !bus_a.halt_req && bus_a.pc_src;
  endfunction

  task automatic model_reset();
    m_edges  = 0;
    m_halted = 1'b0;
    m_fault  = 1'b0;
    m_pc     = RPC_A;
    m_cnt    = '0;
  endtask

  task automatic model_edge();
    if (m_edges < BOOT) begin
      m_edges++;
    end else if (m_halted) begin
      if (bus_a.resume && !m_fault) m_halted = 1'b0;
    end else if (bus_a.halt_req) begin
      m_halted = 1'b1;
    end else if (bus_a.pc_src && (bus_a.branch_target % 4 != 0)) begin
      m_fault  = 1'b1;
      m_halted = 1'b1;
    end else if (bus_a.pc_src) begin
      m_pc = bus_a.branch_target;
    end else if (!bus_a.stall) begin
      m_pc  = m_pc + 32'd4;
      m_cnt = m_cnt + 32'd1;
    end
  endtask

  // Apply inputs just after an edge and let combinational outputs settle.
  task automatic drive(input logic s, input logic p, input word_t t,
                       input logic h, input logic r);
    bus_a.stall         = s;
    bus_a.pc_src        = p;
    bus_a.branch_target = t;
    bus_a.halt_req      = h;
    bus_a.resume        = r;
    #1;
  endtask

  task automatic tick();
    if (!reset_a) model_edge();
    @(posedge clk);
    #1;
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset();
    reset_a = 1'b1;
    model_reset();
    for (int k = 0; k < 3; k++) begin
      drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), word_t'($urandom),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      checks++; if (bus_a.pc !== RPC_A) begin errors++;
        $display("FAIL reset_pc: got %h expected %h", bus_a.pc, RPC_A); end
      checks++; if (bus_a.fetch_valid !== 1'b0 || bus_a.flush !== 1'b0) begin errors++;
        $display("FAIL reset_comb: valid=%b flush=%b expected 0/0", bus_a.fetch_valid, bus_a.flush); end
      checks++; if (bus_a.fault !== 1'b0 || bus_a.fetch_count !== 32'd0) begin errors++;
        $display("FAIL reset_regs: fault=%b count=%0d expected 0/0", bus_a.fault, bus_a.fetch_count); end
      tick();
    end
  endtask

  task automatic test_boot();
    reset_a = 1'b0;
    for (int k = 0; k < BOOT; k++) begin
      // Inputs are ignored during boot, including misaligned branches.
      drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), word_t'($urandom) | 32'h1,
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      checks++; if (bus_a.fetch_valid !== 1'b0 || bus_a.flush !== 1'b0) begin errors++;
        $display("FAIL boot_idle c%0d: valid=%b flush=%b expected 0/0", k, bus_a.fetch_valid, bus_a.flush); end
      checks++; if (bus_a.pc !== RPC_A) begin errors++;
        $display("FAIL boot_pc c%0d: got %h expected %h", k, bus_a.pc, RPC_A); end
      tick();
    end
    drive(0, 0, '0, 0, 0);
    checks++; if (bus_a.fetch_valid !== 1'b1 || bus_a.pc !== 32'h0) begin errors++;
      $display("FAIL boot_first: valid=%b pc=%h expected 1/00000000", bus_a.fetch_valid, bus_a.pc); end
    tick();
    checks++; if (bus_a.fetch_valid !== 1'b1 || bus_a.pc !== 32'h4) begin errors++;
      $display("FAIL boot_second: valid=%b pc=%h expected 1/00000004", bus_a.fetch_valid, bus_a.pc); end
    tick();
    checks++; if (bus_a.pc !== 32'h8 || bus_a.fetch_count !== 32'd2) begin errors++;
      $display("FAIL boot_count: pc=%h count=%0d expected 00000008/2", bus_a.pc, bus_a.fetch_count); end
  endtask

  task automatic test_branch_stall();
    logic [31:0] c_before;
    drive(0, 0, '0, 0, 0);
    tick();
    tick();
    checks++; if (bus_a.pc !== 32'h10) begin errors++;
      $display("FAIL br_setup_pc: got %h expected 00000010", bus_a.pc); end
    c_before = m_cnt;
    drive(1, 1, 32'h40, 0, 0);
    checks++; if (bus_a.flush !== 1'b1 || bus_a.fetch_valid !== 1'b0) begin errors++;
      $display("FAIL br_stall_comb: flush=%b valid=%b expected 1/0", bus_a.flush, bus_a.fetch_valid); end
    tick();
    drive(0, 0, '0, 0, 0);
    checks++; if (bus_a.pc !== 32'h40 || bus_a.fetch_count !== c_before) begin errors++;
      $display("FAIL br_stall_after: pc=%h count=%0d expected 00000040/%0d", bus_a.pc, bus_a.fetch_count, c_before); end
    // Unstalled branch: fetch_valid stays high but the flushed fetch is not counted.
    c_before = m_cnt;
    drive(0, 1, 32'h80, 0, 0);
    checks++; if (bus_a.flush !== 1'b1 || bus_a.fetch_valid !== 1'b1) begin errors++;
      $display("FAIL br_run_comb: flush=%b valid=%b expected 1/1", bus_a.flush, bus_a.fetch_valid); end
    tick();
    drive(0, 0, '0, 0, 0);
    checks++; if (bus_a.pc !== 32'h80 || bus_a.fetch_count !== c_before) begin errors++;
      $display("FAIL br_run_after: pc=%h count=%0d expected 00000080/%0d", bus_a.pc, bus_a.fetch_count, c_before); end
  endtask

  task automatic test_halt_resume();
    drive(0, 1, 32'h20, 0, 0);
    tick();
    drive(0, 0, '0, 1, 0);
    checks++; if (bus_a.fetch_valid !== 1'b0 || bus_a.flush !== 1'b0 || bus_a.pc !== 32'h20) begin errors++;
      $display("FAIL halt_req: valid=%b flush=%b pc=%h expected 0/0/00000020", bus_a.fetch_valid, bus_a.flush, bus_a.pc); end
    tick();
    for (int k = 0; k < 5; k++) begin
      drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), word_t'($urandom) & ~32'h3, 0, 0);
      checks++; if (bus_a.pc !== 32'h20 || bus_a.fetch_valid !== 1'b0 || bus_a.flush !== 1'b0) begin errors++;
        $display("FAIL halt_hold c%0d: pc=%h valid=%b flush=%b expected 00000020/0/0", k, bus_a.pc, bus_a.fetch_valid, bus_a.flush); end
      tick();
    end
    drive(0, 0, '0, 0, 1);
    checks++; if (bus_a.fetch_valid !== 1'b0) begin errors++;
      $display("FAIL resume_cycle: valid=%b expected 0", bus_a.fetch_valid); end
    tick();
    drive(0, 0, '0, 0, 0);
    checks++; if (bus_a.fetch_valid !== 1'b1 || bus_a.pc !== 32'h20) begin errors++;
      $display("FAIL resume_first: valid=%b pc=%h expected 1/00000020", bus_a.fetch_valid, bus_a.pc); end
    tick();
    checks++; if (bus_a.pc !== 32'h24) begin errors++;
      $display("FAIL resume_next: pc=%h expected 00000024", bus_a.pc); end
  endtask

  task automatic test_random();
    for (int k = 0; k < 400; k++) begin
      drive(1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 5) == 0),
            word_t'($urandom) & ~32'h3, 1'($urandom_range(0, 9) == 0),
            1'($urandom_range(0, 2) == 0));
      checks++;
      if (bus_a.pc !== m_pc || bus_a.fetch_valid !== exp_valid() || bus_a.flush !== exp_flush() ||
          bus_a.fault !== m_fault || bus_a.fetch_count !== m_cnt) begin
        errors++;
        $display("FAIL random c%0d: pc=%h valid=%b flush=%b fault=%b count=%0d expected %h/%b/%b/%b/%0d",
                 k, bus_a.pc, bus_a.fetch_valid, bus_a.flush, bus_a.fault, bus_a.fetch_count,
                 m_pc, exp_valid(), exp_flush(), m_fault, m_cnt);
      end
      tick();
    end
  endtask

  task automatic test_misaligned();
    word_t p;
    drive(0, 0, '0, 0, 1);   // leaves HALT if the random run ended there
    tick();
    p = m_pc;
    drive(0, 1, 32'h42, 0, 0);
    checks++; if (bus_a.flush !== 1'b1) begin errors++;
      $display("FAIL mis_flush: got %b expected 1", bus_a.flush); end
    tick();
    for (int k = 0; k < 4; k++) begin
      drive(0, 0, '0, 0, 1'(k != 0));
      checks++; if (bus_a.fault !== 1'b1 || bus_a.fetch_valid !== 1'b0 || bus_a.pc !== p) begin errors++;
        $display("FAIL mis_halt c%0d: fault=%b valid=%b pc=%h expected 1/0/%h", k, bus_a.fault, bus_a.fetch_valid, bus_a.pc, p); end
      tick();
    end
    reset_a = 1'b1;
    model_reset();
    #1;
    checks++; if (bus_a.fault !== 1'b0 || bus_a.pc !== RPC_A) begin errors++;
      $display("FAIL mis_reset: fault=%b pc=%h expected 0/%h", bus_a.fault, bus_a.pc, RPC_A); end
  endtask

  task automatic test_mid_boot_reset();
    drive(0, 0, '0, 0, 0);
    tick();
    reset_a = 1'b0;
    tick();
    tick();
    reset_a = 1'b1;            // asserted in boot cycle 2
    model_reset();
    #1;
    checks++; if (bus_a.pc !== RPC_A || bus_a.fetch_valid !== 1'b0) begin errors++;
      $display("FAIL mb_reset: pc=%h valid=%b expected %h/0", bus_a.pc, bus_a.fetch_valid, RPC_A); end
    tick();
    reset_a = 1'b0;
    for (int k = 0; k < BOOT; k++) begin
      drive(0, 0, '0, 0, 0);
      checks++; if (bus_a.fetch_valid !== 1'b0) begin errors++;
        $display("FAIL mb_boot c%0d: valid=%b expected 0", k, bus_a.fetch_valid); end
      tick();
    end
    checks++; if (bus_a.fetch_valid !== 1'b1 || bus_a.pc !== RPC_A) begin errors++;
      $display("FAIL mb_first: valid=%b pc=%h expected 1/%h", bus_a.fetch_valid, bus_a.pc, RPC_A); end
    tick();
    tick();
    // Asynchronous reset in the middle of a RUN cycle, no clock edge needed.
    #2 reset_a = 1'b1;
    model_reset();
    #1;
    checks++; if (bus_a.pc !== RPC_A || bus_a.fetch_count !== 32'd0 || bus_a.fetch_valid !== 1'b0) begin errors++;
      $display("FAIL async_reset: pc=%h count=%0d valid=%b expected %h/0/0", bus_a.pc, bus_a.fetch_count, bus_a.fetch_valid, RPC_A); end
    tick();
  endtask

  task automatic test_wrap();
    reset_b = 1'b0;
    for (int k = 0; k < BOOT; k++) begin
      @(posedge clk);
      #1;
    end
    checks++; if (bus_b.fetch_valid !== 1'b1 || bus_b.pc !== 32'hFFFF_FFF8) begin errors++;
      $display("FAIL wrap_0: valid=%b pc=%h expected 1/fffffff8", bus_b.fetch_valid, bus_b.pc); end
    @(posedge clk); #1;
    checks++; if (bus_b.pc !== 32'hFFFF_FFFC) begin errors++;
      $display("FAIL wrap_1: pc=%h expected fffffffc", bus_b.pc); end
    @(posedge clk); #1;
    checks++; if (bus_b.pc !== 32'h0 || bus_b.fetch_count !== 32'd2) begin errors++;
      $display("FAIL wrap_2: pc=%h count=%0d expected 00000000/2", bus_b.pc, bus_b.fetch_count); end
  endtask

  // ---------------------------------------------------------------------------
  initial begin
    reset_a = 1'b1;
    reset_b = 1'b1;
    bus_b.stall         = 1'b0;
    bus_b.pc_src        = 1'b0;
    bus_b.branch_target = '0;
    bus_b.halt_req      = 1'b0;
    bus_b.resume        = 1'b0;
    model_reset();
    drive(0, 0, '0, 0, 0);
    @(posedge clk);
    #1;
    test_reset();
    test_boot();
    test_branch_stall();
    test_halt_resume();
    test_random();
    test_misaligned();
    test_mid_boot_reset();
    test_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule : tb_fetch_ctrl
